// File: rtl/apb_slave_regbank.sv
// apb_slave_regbank: APB completer with byte-strobed RW control registers,
// read-only status registers, fixed wait states and PSLVERR on bad accesses.
module apb_slave_regbank #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int STRB_WIDTH    = 4,
    parameter int REG_NUM       = 8,
    parameter int RO_BASE       = 6,
    parameter int WAIT_CYCLES   = 1
) (
    input  logic                                    PCLK,
    input  logic                                    PRESETn,
    input  logic                                    PSEL,
    input  logic                                    PENABLE,
    input  logic                                    PWRITE,
    input  logic [ADDRESS_WIDTH-1:0]                PADDR,
    input  logic [DATA_WIDTH-1:0]                   PWDATA,
    input  logic [STRB_WIDTH-1:0]                   PSTRB,
    input  logic [(REG_NUM-RO_BASE)*DATA_WIDTH-1:0] status_in,
    output logic [DATA_WIDTH-1:0]                   PRDATA,
    output logic                                    PREADY,
    output logic                                    PSLVERR,
    output logic [RO_BASE*DATA_WIDTH-1:0]           ctrl_out,
    output logic [RO_BASE-1:0]                      wr_pulse
);
    localparam int IW = ADDRESS_WIDTH - 2;
    localparam int XW = REG_NUM > 1 ? $clog2(REG_NUM) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    state_t                             state;
    logic [RO_BASE-1:0][DATA_WIDTH-1:0] regs;
    logic [XW-1:0]                      idx;
    logic                               wr;
    logic                               err;
    logic [DATA_WIDTH-1:0]              wdata;
    logic [STRB_WIDTH-1:0]              strb;
    logic [3:0]                         cnt;
    logic [IW-1:0]                      pidx;
    logic                               set_err;
    logic [XW-1:0]                      cur_idx;
    logic                               cur_wr;
    logic                               cur_err;
    logic [DATA_WIDTH-1:0]              rd_val;

    assign pidx     = PADDR[ADDRESS_WIDTH-1:2];
    assign set_err  = (PADDR[1:0] != 2'b00) || (pidx >= IW'(REG_NUM)) || (PWRITE && pidx >= IW'(RO_BASE));
    assign ctrl_out = regs;

    // With zero wait states ACK is entered straight from setup, so the
    // response must be built from the live bus rather than the latched copy.
    assign cur_idx = state == IDLE ? XW'(pidx) : idx;
    assign cur_wr  = state == IDLE ? PWRITE : wr;
    assign cur_err = state == IDLE ? set_err : err;

    always_comb begin
        rd_val = '0;
        for (int k = 0; k < RO_BASE; k++)
            if (cur_idx == XW'(k)) rd_val = regs[k];
        for (int k = RO_BASE; k < REG_NUM; k++)
            if (cur_idx == XW'(k)) rd_val = status_in[(k-RO_BASE)*DATA_WIDTH +: DATA_WIDTH];
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state    <= IDLE;
            regs     <= '0;
            idx      <= '0;
            wr       <= 1'b0;
            err      <= 1'b0;
            wdata    <= '0;
            strb     <= '0;
            cnt      <= '0;
            PRDATA   <= '0;
            PREADY   <= 1'b0;
            PSLVERR  <= 1'b0;
            wr_pulse <= '0;
        end else begin
            wr_pulse <= '0;
            case (state)
                IDLE: if (PSEL && !PENABLE) begin
                    idx   <= XW'(pidx);
                    wr    <= PWRITE;
                    wdata <= PWDATA;
                    strb  <= PSTRB;
                    err   <= set_err;
                    cnt   <= 4'(WAIT_CYCLES);
                    if (WAIT_CYCLES == 0) begin
                        state   <= ACK;
                        PREADY  <= 1'b1;
                        PSLVERR <= cur_err;
                        PRDATA  <= (cur_wr || cur_err) ? '0 : rd_val;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: if (!PSEL) begin
                    state <= IDLE;
                end else if (cnt <= 4'd1) begin
                    state   <= ACK;
                    PREADY  <= 1'b1;
                    PSLVERR <= cur_err;
                    PRDATA  <= (cur_wr || cur_err) ? '0 : rd_val;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                ACK: begin
                    state   <= IDLE;
                    PREADY  <= 1'b0;
                    PSLVERR <= 1'b0;
                    PRDATA  <= '0;
                    if (PSEL && PENABLE && wr && !err)
                        for (int i = 0; i < RO_BASE; i++)
                            if (idx == XW'(i)) begin
                                wr_pulse[i] <= 1'b1;
                                for (int b = 0; b < STRB_WIDTH; b++)
                                    if (strb[b]) regs[i][b*8 +: 8] <= wdata[b*8 +: 8];
                            end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_slave_regbank.sv
// tb_apb_slave_regbank: scoreboard bench driving three builds (1, 0 and 3
// wait states) of the register bank over a shared APB bus with private PSELs.
module tb_apb_slave_regbank;
    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic [2:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [63:0] status_in = {32'hCAFE_0007, 32'hBEEF_0006};
    logic [31:0]  prdata [3];
    logic         ready  [3];
    logic         slverr [3];
    logic [191:0] ctrl   [3];
    logic [5:0]   wrp    [3];

    int   wc [3] = '{1, 0, 3};
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_ack = 0;
    exp_t sb [$];

    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        apb_slave_regbank #(.WAIT_CYCLES(g == 0 ? 1 : g == 1 ? 0 : 3)) dut (
            .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[g]), .PENABLE(penable),
            .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
            .status_in(status_in), .PRDATA(prdata[g]), .PREADY(ready[g]),
            .PSLVERR(slverr[g]), .ctrl_out(ctrl[g]), .wr_pulse(wrp[g]));
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle();
        @(posedge PCLK); #1;
        psel    = '0;
        penable = 1'b0;
    endtask

    task automatic xfer(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] st, input logic [31:0] erd, input bit eerr);
        exp_t e;
        int   c;
        e.rdata = erd;
        e.err   = eerr;
        e.lat   = wc[d] + 1;
        sb.push_back(e);
        @(posedge PCLK); #1;
        psel    = '0;
        psel[d] = 1'b1;
        penable = 1'b0;
        pwrite  = w;
        paddr   = a;
        pwdata  = wd;
        pstrb   = st;
        @(posedge PCLK); #1;
        penable = 1'b1;
        c = 1;
        @(negedge PCLK);
        while (!ready[d] && c < 20) begin
            @(posedge PCLK); #1;
            c++;
            @(negedge PCLK);
        end
        e = sb.pop_front();
        chk($sformatf("ready d%0d a%0h", d, a), 64'(ready[d]), 64'd1);
        chk($sformatf("latency d%0d a%0h", d, a), 64'(c), 64'(e.lat));
        chk($sformatf("slverr d%0d a%0h", d, a), 64'(slverr[d]), 64'(e.err));
        if (!w) chk($sformatf("rdata d%0d a%0h", d, a), 64'(prdata[d]), 64'(e.rdata));
        last_ack = cyc;
    endtask

    initial begin
        int a1;
        bit seen;
        PRESETn = 1'b0;
        psel    = '0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        pstrb   = '0;
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        for (int d = 0; d < 3; d++) begin
            chk("rst prdata", 64'(prdata[d]), 64'd0);
            chk("rst ready", 64'(ready[d] | slverr[d]), 64'd0);
            chk("rst wrp", 64'(wrp[d]), 64'd0);
            chk("rst ctrl", 64'(|ctrl[d]), 64'd0);
        end
        PRESETn = 1'b1;

        for (int i = 0; i < 8; i++)
            xfer(0, 0, 32'(i * 4), 0, 0, i == 6 ? 32'hBEEF_0006 : i == 7 ? 32'hCAFE_0007 : 32'h0, 0);

        xfer(0, 1, 32'h04, 32'h1122_3344, 4'hF, 0, 0);
        xfer(0, 1, 32'h04, 32'hAABB_CCDD, 4'b0101, 0, 0);
        idle();
        @(negedge PCLK);
        chk("wr_pulse on", 64'(wrp[0]), 64'b000010);
        chk("ctrl1", 64'(ctrl[0][63:32]), 64'h11BB_33DD);
        @(posedge PCLK); #1;
        @(negedge PCLK);
        chk("wr_pulse off", 64'(wrp[0]), 64'd0);
        xfer(0, 0, 32'h04, 0, 0, 32'h11BB_33DD, 0);

        xfer(0, 1, 32'h18, 32'hDEAD_BEEF, 4'hF, 0, 1);
        idle();
        @(negedge PCLK);
        chk("ro wr_pulse", 64'(wrp[0]), 64'd0);
        chk("ro ctrl", 64'(ctrl[0][63:32]), 64'h11BB_33DD);
        xfer(0, 0, 32'h18, 0, 4'hF, 32'hBEEF_0006, 0);
        xfer(0, 0, 32'h20, 0, 0, 0, 1);
        xfer(0, 0, 32'h02, 0, 0, 0, 1);
        status_in[31:0] = 32'h1234_5678;
        xfer(0, 0, 32'h18, 0, 0, 32'h1234_5678, 0);

        for (int d = 1; d < 3; d++) begin
            xfer(d, 1, 32'h08, 32'h5A5A_0000 + 32'(d), 4'hF, 0, 0);
            a1 = last_ack;
            xfer(d, 0, 32'h08, 0, 0, 32'h5A5A_0000 + 32'(d), 0);
            chk($sformatf("b2b gap d%0d", d), 64'(last_ack - a1), 64'(wc[d] + 2));
            idle();
        end

        @(posedge PCLK); #1;
        psel[1] = 1'b1;
        penable = 1'b1;
        seen = 0;
        repeat (3) begin
            @(negedge PCLK);
            seen |= ready[1];
        end
        chk("penable in idle", 64'(seen), 64'd0);
        idle();

        xfer(2, 1, 32'h0C, 32'h3333_3333, 4'hF, 0, 0);
        idle();
        @(posedge PCLK); #1;
        psel[2] = 1'b1;
        pwrite  = 1'b1;
        paddr   = 32'h0C;
        pwdata  = 32'h9999_9999;
        @(posedge PCLK); #1;
        penable = 1'b1;
        @(posedge PCLK); #1;
        psel    = '0;
        penable = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge PCLK);
            seen |= ready[2];
        end
        chk("abort ready", 64'(seen), 64'd0);
        chk("abort ctrl3", 64'(ctrl[2][127:96]), 64'h3333_3333);
        xfer(2, 0, 32'h0C, 0, 0, 32'h3333_3333, 0);

        @(posedge PCLK); #1;
        psel[2] = 1'b1;
        pwrite  = 1'b0;
        paddr   = 32'h18;
        @(posedge PCLK); #1;
        penable = 1'b1;
        @(negedge PCLK); #1;
        PRESETn = 1'b0;
        #1;
        chk("mid rst ready", 64'(ready[2] | slverr[2]), 64'd0);
        chk("mid rst prdata", 64'(prdata[2]), 64'd0);
        chk("mid rst ctrl2", 64'(|ctrl[2]), 64'd0);
        chk("mid rst ctrl0", 64'(|ctrl[0]), 64'd0);
        chk("mid rst wrp", 64'(wrp[2]), 64'd0);
        idle();
        PRESETn = 1'b1;
        xfer(2, 0, 32'h0C, 0, 0, 32'h0, 0);
        xfer(0, 0, 32'h04, 0, 0, 32'h0, 0);
        idle();
        repeat (2) @(posedge PCLK);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
